// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer.
// Sends a start bit, DATA_WIDTH data bits (LSB first), an optional parity bit
// and a stop bit. Each bit lasts Prescale clocks of the oversampling clock.
// Optional feature macro: UART_TX_PARITY_EN builds the PARITY state and parity
// logic. Without it, PAR_EN/PAR_TYP are ignored and every frame is 10 bits.
module uart_tx_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] edge_count_q, edge_count_d;
    logic [BIT_W-1:0]          bit_count_q, bit_count_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      last_edge;
    logic [BIT_W-1:0]          bit_next;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
`else
    // Parity inputs are intentionally unused when parity is not built.
    logic unused_parity;
    assign unused_parity = PAR_EN ^ PAR_TYP;
`endif

    // Only 8, 16 and 32 are valid bit lengths; anything else falls back to 16.
    function automatic logic [PRESCALE_WIDTH-1:0] legal_prescale(
        input logic [PRESCALE_WIDTH-1:0] p
    );
        if (p == PRESCALE_WIDTH'(8) || p == PRESCALE_WIDTH'(16) ||
            p == PRESCALE_WIDTH'(32))
            return p;
        return PRESCALE_WIDTH'(16);
    endfunction

    assign last_edge = (edge_count_q == (prescale_q - 1'b1));
    assign bit_next  = bit_count_q + 1'b1;

    // Next-state logic; tx_d/busy_d are the values for the state being entered,
    // so the registered outputs line up with the state without a cycle of lag.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        prescale_d   = prescale_q;
        edge_count_d = edge_count_q;
        bit_count_d  = bit_count_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
`ifdef UART_TX_PARITY_EN
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    data_d       = P_DATA;
                    prescale_d   = legal_prescale(Prescale);
`ifdef UART_TX_PARITY_EN
                    par_en_d     = PAR_EN;
                    par_typ_d    = PAR_TYP;
`endif
                    edge_count_d = '0;
                    bit_count_d  = '0;
                    state_d      = START;
                    tx_d         = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            START: begin
                if (last_edge) begin
                    edge_count_d = '0;
                    bit_count_d  = '0;
                    state_d      = DATA;
                    tx_d         = data_q[0];
                end else begin
                    edge_count_d = edge_count_q + 1'b1;
                end
            end
            DATA: begin
                if (last_edge) begin
                    edge_count_d = '0;
                    if (bit_count_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = (^data_q) ^ par_typ_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_count_d = bit_next;
                        tx_d        = data_q[bit_next];
                    end
                end else begin
                    edge_count_d = edge_count_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_edge) begin
                    edge_count_d = '0;
                    state_d      = STOP;
                    tx_d         = 1'b1;
                end else begin
                    edge_count_d = edge_count_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (last_edge) begin
                    edge_count_d = '0;
                    state_d      = IDLE;
                    tx_d         = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    edge_count_d = edge_count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, frame latches and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            prescale_q   <= PRESCALE_WIDTH'(16);
            edge_count_q <= '0;
            bit_count_q  <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            prescale_q   <= prescale_d;
            edge_count_q <= edge_count_d;
            bit_count_q  <= bit_count_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
`endif
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed testbench for uart_tx_serializer: frames are checked bit-by-bit,
// cycle-by-cycle against expected frames built from the stimulus values.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call just after a negedge. Requests a frame at the next posedge and checks
    // every cycle of it, then the idle state after edge N + F*P.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [5:0] p_in,
                             input int p_exp, input logic pe, input logic pt,
                             input bit hold, input bit disturb);
        logic exp_bits [0:10];
        int   nbits;
        exp_bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) exp_bits[b+1] = d[b];
        if (pe && PARITY_BUILT) begin
            exp_bits[9]  = (^d) ^ pt;
            exp_bits[10] = 1'b1;
            nbits = 11;
        end else begin
            exp_bits[9] = 1'b1;
            nbits = 10;
        end
        P_DATA     = d;
        Prescale   = p_in;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < nbits * p_exp; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) Data_Valid = 1'b0;
            if (disturb && i == 4 * p_exp) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                Prescale   = 6'd8;
                PAR_EN     = ~pe;
                PAR_TYP    = ~pt;
            end
            if (disturb && i == 4 * p_exp + 1) Data_Valid = 1'b0;
            chk($sformatf("%s_bit%0d_c%0d", tag, i / p_exp, i % p_exp), TX_OUT, exp_bits[i / p_exp]);
            chk($sformatf("%s_busy_c%0d", tag, i), busy, 1);
        end
        @(negedge clk);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_tx"}, TX_OUT, 1);
    endtask

    initial begin
        rst = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        Prescale = 6'd16;
        repeat (3) @(negedge clk);
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tx", TX_OUT, 1);
        chk("idle_busy", busy, 0);

        // No parity, P=16, 0xA5
        run_frame("nopar", 8'hA5, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        // Even and odd parity, P=8, 0x07
        run_frame("even", 8'h07, 6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("odd", 8'h07, 6'd8, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        // Mid-frame request and input changes ignored
        run_frame("busyreq", 8'h3C, 6'd32, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("noq_busy_c%0d", i), busy, 0);
            chk($sformatf("noq_tx_c%0d", i), TX_OUT, 1);
        end
        // Back-to-back with Data_Valid held high: one idle cycle between frames
        run_frame("b2b0", 8'h55, 6'd8, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("b2b1", 8'h55, 6'd8, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        Data_Valid = 1'b0;
        @(negedge clk);

        // Reset during data bit 3 (frame bit index 4)
        P_DATA = 8'hA5; Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (4 * 16 + 4) @(negedge clk);
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_tx", TX_OUT, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", TX_OUT, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        run_frame("after_rst", 8'hA5, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal prescale 12 behaves as 16; parity only when built
        run_frame("illegal_p", 8'h81, 6'd12, 16, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit half of the UART block. It accepts a parallel byte with a valid strobe and serializes it onto `TX_OUT` as a start bit, 8 data bits (LSB first), an optional parity bit and a stop bit. Each bit lasts `Prescale` cycles of the oversampling clock, so transmitter and receiver share one clock and one prescale setting. It sits between the host-side register interface and the serial line.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: payload bits per frame.
- `PRESCALE_WIDTH`, default 6: width of the `Prescale` input.

**Ports**
- `clk` in 1: oversampling clock, Prescale × baud rate.
- `rst` in 1: asynchronous, active-high reset.
- `P_DATA` in DATA_WIDTH: byte to transmit, sampled on acceptance.
- `Data_Valid` in 1: request strobe, accepted only when `busy` = 0.
- `PAR_EN` in 1: 1 appends a parity bit. Sampled on acceptance.
- `PAR_TYP` in 1: 0 selects even parity, 1 selects odd. Sampled on acceptance.
- `Prescale` in PRESCALE_WIDTH: clocks per bit, one of 8, 16 or 32. Sampled on acceptance.
- `TX_OUT` out 1: registered serial line output.
- `busy` out 1: registered; high while a frame is in progress.

## Operation

- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Bit timing:** `edge_count` counts 0..P−1 within each bit, where P is the latched prescale. A bit ends when `edge_count` = P−1. `bit_count` counts 0..DATA_WIDTH−1 within DATA.
- **IDLE:** `TX_OUT` = 1, `busy` = 0. If `Data_Valid` = 1 at a clock edge:
  - latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`;
  - go to START, clear counters.
- **START:** `TX_OUT` = 0 for P cycles, then go to DATA.
- **DATA:** `TX_OUT` = latched data[`bit_count`], LSB first, P cycles per bit. After bit DATA_WIDTH−1, go to PARITY if the latched PAR_EN = 1, otherwise go to STOP.
- **PARITY:** `TX_OUT` = ^data XOR latched PAR_TYP for P cycles, then go to STOP.
- **STOP:** `TX_OUT` = 1 for P cycles, then go to IDLE.
- **Busy while sending:** `Data_Valid` while `busy` = 1 is ignored and is not queued.
- **Stable frame settings:** changes on `P_DATA`, `PAR_EN`, `PAR_TYP` or `Prescale` mid-frame have no effect on the current frame.
- **Illegal prescale:** a latched `Prescale` value other than 8, 16 or 32 is treated as 16.
- **Reset:** asynchronous assertion at any time forces:
  - state IDLE, `TX_OUT` = 1, `busy` = 0;
  - counters and the data latch cleared.

  A frame in progress is aborted and the line returns to idle-high immediately.

## Timing

- **Reset values:** `TX_OUT` = 1, `busy` = 0.
- **Acceptance:** `Data_Valid` = 1 sampled in IDLE at edge N.
- **Start of frame:** `TX_OUT` = 0 and `busy` = 1 from edge N onward. Both outputs are registered with no combinational path from the inputs.
- **Frame length:** F = 10 bits (11 with parity). `TX_OUT` holds each bit for exactly P cycles.
- **End of frame:** at edge N + F·P the state returns to IDLE, `busy` = 0 and `TX_OUT` = 1.
- **Back-to-back frames:** the earliest next acceptance is edge N + F·P + 1. There is therefore a minimum idle-high gap of 1 clock between frames.
- **Continuous request:** `Data_Valid` held high continuously sends the same byte repeatedly, re-sampling `P_DATA` at each acceptance.

## Configuration

- **`UART_TX_PARITY_EN` defined:** the PARITY state and parity logic are built; `PAR_EN` and `PAR_TYP` behave as above.
- **`UART_TX_PARITY_EN` undefined:**
  - the PARITY state and logic are removed;
  - `PAR_EN` and `PAR_TYP` ports remain but are ignored;
  - every frame is 10 bits and DATA always goes to STOP.

## Test plan

- **No parity:** reset, P = 16, PAR_EN = 0, `P_DATA` = 0xA5 with 1-cycle `Data_Valid` -> `TX_OUT` = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; `busy` high 160 cycles, then low.
- **Even parity:** P = 8, PAR_EN = 1, PAR_TYP = 0, `P_DATA` = 0x07 -> after the data bits, parity bit = 1; 11-bit frame of 88 cycles. Repeat with PAR_TYP = 1 -> parity bit = 0.
- **Busy-time requests and input changes:** P = 32, `P_DATA` = 0x3C accepted, then `Data_Valid` pulsed mid-frame and `P_DATA` changed to 0xFF -> transmitted byte is 0x3C; no second frame follows.
- **Back-to-back:** `Data_Valid` held high with `P_DATA` = 0x55, P = 8 -> consecutive 80-cycle frames separated by exactly 1 idle-high cycle.
- **Reset mid-frame:** assert `rst` during data bit 3 -> `TX_OUT` = 1 and `busy` = 0 immediately (asynchronously). After release, a new request sends a complete, correct frame.
- **Illegal prescale and macro-off build:** `Prescale` = 12 -> 16 cycles per bit. With `UART_TX_PARITY_EN` undefined and PAR_EN = 1 -> 10-bit frame.
